// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS-style pipeline stages.
//   - Opcode constants for the instructions the memory stage cares about.
//   - State encoding for mem_access_stage.
//   - writes_reg(): whether an opcode produces a register result.
package mips_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned REG_W  = 5;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWb
  } mem_stage_state_e;

  // R-type, lw and the I-type ALU group (opcodes 001xxx) write the register file.
  function automatic logic writes_reg(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op[5:3] == 3'b001);
  endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// Counts request cycles that went unacknowledged and flags the last allowed one.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_clear        : synchronous clear (held while no request is outstanding)
//   i_enable       : a request cycle without acknowledge
//   o_expired      : this enabled cycle is the TIMEOUT-th unacknowledged one
module mem_timeout_counter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] r_count;

  // Count holds the number of earlier unacknowledged cycles, so the TIMEOUT-th
  // such cycle is the one that sees TIMEOUT-1.
  assign o_expired = i_enable & (r_count == CntW'(TIMEOUT - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && !o_expired) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: accepts one executed instruction per handshake,
// performs the lw/sw data-memory access over a req/ack port with timeout, and
// presents a single write-back beat. Other instructions pass through in one cycle.
// Ports:
//   i_clk, i_rst_n                : clock, asynchronous active-low reset
//   i_in_valid / o_in_ready       : upstream handshake
//   i_opcode, i_result, i_rt_val,
//   i_dest, i_sig_b               : executed instruction fields
//   o_mem_req/we/addr/wdata       : data-memory request, held until ack or timeout
//   i_mem_rdata, i_mem_ack        : memory response (one-cycle ack pulse)
//   o_wb_valid / i_wb_ready       : write-back handshake
//   o_wb_en/dest/data             : register write
//   o_branch_taken, o_misalign,
//   o_bus_err                     : beat status flags
module mem_access_stage
  import mips_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [5:0]        i_opcode,
  input  logic [WORD_W-1:0] i_result,
  input  logic [WORD_W-1:0] i_rt_val,
  input  logic [REG_W-1:0]  i_dest,
  input  logic              i_sig_b,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [WORD_W-1:0] o_mem_addr,
  output logic [WORD_W-1:0] o_mem_wdata,
  input  logic [WORD_W-1:0] i_mem_rdata,
  input  logic              i_mem_ack,
  output logic              o_wb_valid,
  input  logic              i_wb_ready,
  output logic              o_wb_en,
  output logic [REG_W-1:0]  o_wb_dest,
  output logic [WORD_W-1:0] o_wb_data,
  output logic              o_branch_taken,
  output logic              o_misalign,
  output logic              o_bus_err
);

  mem_stage_state_e r_state, w_state_next;

  logic              w_accept;
  logic              w_is_mem;
  logic              w_misalign;
  logic              w_expired;
  logic              w_cnt_clear;
  logic              w_cnt_en;

  logic              r_mem_we;
  logic [WORD_W-1:0] r_mem_addr;
  logic [WORD_W-1:0] r_mem_wdata;
  logic              r_is_lw;
  logic              r_wb_en;
  logic [REG_W-1:0]  r_wb_dest;
  logic [WORD_W-1:0] r_wb_data;
  logic              r_branch;
  logic              r_misalign;
  logic              r_bus_err;

  assign o_in_ready = (r_state == StIdle) | ((r_state == StWb) & i_wb_ready);
  assign w_accept   = i_in_valid & o_in_ready;
  assign w_is_mem   = (i_opcode == OP_LW) | (i_opcode == OP_SW);
  assign w_misalign = w_is_mem & (i_result[1:0] != 2'b00);

  // Ack on the final allowed cycle wins: the counter is only enabled without ack.
  assign w_cnt_clear = (r_state != StReq);
  assign w_cnt_en    = (r_state == StReq) & ~i_mem_ack;

  mem_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clear   (w_cnt_clear),
    .i_enable  (w_cnt_en),
    .o_expired (w_expired)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle, StWb: begin
        if (w_accept) begin
          w_state_next = (w_is_mem && !w_misalign) ? StReq : StWb;
        end else if ((r_state == StWb) && i_wb_ready) begin
          w_state_next = StIdle;
        end
      end
      StReq: begin
        if (i_mem_ack || w_expired) begin
          w_state_next = StWb;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_is_lw     <= 1'b0;
      r_wb_en     <= 1'b0;
      r_wb_dest   <= '0;
      r_wb_data   <= '0;
      r_branch    <= 1'b0;
      r_misalign  <= 1'b0;
      r_bus_err   <= 1'b0;
    end else if (w_accept) begin
      r_mem_we    <= (i_opcode == OP_SW);
      r_mem_addr  <= i_result;
      r_mem_wdata <= i_rt_val;
      r_is_lw     <= (i_opcode == OP_LW);
      r_wb_en     <= writes_reg(i_opcode) & (i_dest != '0) & ~w_misalign;
      r_wb_dest   <= i_dest;
      r_wb_data   <= i_result;
      r_branch    <= i_sig_b & ((i_opcode == OP_BEQ) | (i_opcode == OP_BNE));
      r_misalign  <= w_misalign;
      r_bus_err   <= 1'b0;
    end else if (r_state == StReq) begin
      if (i_mem_ack) begin
        if (r_is_lw) begin
          r_wb_data <= i_mem_rdata;
        end
      end else if (w_expired) begin
        r_bus_err <= 1'b1;
        r_wb_en   <= 1'b0;
      end
    end
  end

  assign o_mem_req      = (r_state == StReq);
  assign o_mem_we       = r_mem_we;
  assign o_mem_addr     = r_mem_addr;
  assign o_mem_wdata    = r_mem_wdata;
  assign o_wb_valid     = (r_state == StWb);
  assign o_wb_en        = r_wb_en;
  assign o_wb_dest      = r_wb_dest;
  assign o_wb_data      = r_wb_data;
  assign o_branch_taken = r_branch;
  assign o_misalign     = r_misalign;
  assign o_bus_err      = r_bus_err;

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

  localparam int unsigned TIMEOUT = 16;
  localparam int NRAND = 150;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_in_valid;
  logic        o_in_ready;
  logic [5:0]  i_opcode;
  logic [31:0] i_result;
  logic [31:0] i_rt_val;
  logic [4:0]  i_dest;
  logic        i_sig_b;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [31:0] i_mem_rdata;
  logic        i_mem_ack;
  logic        o_wb_valid;
  logic        i_wb_ready;
  logic        o_wb_en;
  logic [4:0]  o_wb_dest;
  logic [31:0] o_wb_data;
  logic        o_branch_taken;
  logic        o_misalign;
  logic        o_bus_err;

  mem_access_stage #(
    .TIMEOUT (TIMEOUT)
  ) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_in_valid     (i_in_valid),
    .o_in_ready     (o_in_ready),
    .i_opcode       (i_opcode),
    .i_result       (i_result),
    .i_rt_val       (i_rt_val),
    .i_dest         (i_dest),
    .i_sig_b        (i_sig_b),
    .o_mem_req      (o_mem_req),
    .o_mem_we       (o_mem_we),
    .o_mem_addr     (o_mem_addr),
    .o_mem_wdata    (o_mem_wdata),
    .i_mem_rdata    (i_mem_rdata),
    .i_mem_ack      (i_mem_ack),
    .o_wb_valid     (o_wb_valid),
    .i_wb_ready     (i_wb_ready),
    .o_wb_en        (o_wb_en),
    .o_wb_dest      (o_wb_dest),
    .o_wb_data      (o_wb_data),
    .o_branch_taken (o_branch_taken),
    .o_misalign     (o_misalign),
    .o_bus_err      (o_bus_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // ---------------- table vectors: single-beat instructions ----------------
  typedef struct {
    logic [5:0]  op;
    logic [31:0] res;
    logic [4:0]  dest;
    logic        sig_b;
    logic        en;
    logic [31:0] data;
    logic        chk_data;
    logic        br;
    logic        mis;
  } vec_t;

  vec_t vecs[11];

  // ---------------- random phase: transaction-level model ----------------
  typedef struct {
    logic [5:0]  op;
    logic [31:0] res;
    logic [31:0] rtv;
    logic [4:0]  dest;
    logic        sig_b;
    int          delay;   // REQ cycle carrying the ack; > TIMEOUT means never
  } ins_t;

  typedef struct {
    logic        en;
    logic [4:0]  dest;
    logic [31:0] data;
    logic        chk_data;
    logic        br;
    logic        mis;
    logic        berr;
  } beat_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        we;
    int          delay;
  } req_t;

  beat_t       exp_q[$];
  req_t        req_q[$];
  logic [31:0] mem_model [int unsigned];
  bit          rand_on = 1'b0;
  int          n_beats = 0;

  function automatic ins_t rand_ins();
    ins_t t;
    int   k;
    k = int'($urandom_range(0, 9));
    case (k)
      0:       t.op = 6'd0;
      1:       t.op = 6'd8;
      2:       t.op = 6'd13;
      3:       t.op = 6'd15;
      4, 5:    t.op = 6'd35;
      6, 7:    t.op = 6'd43;
      8:       t.op = ($urandom_range(0, 1) == 0) ? 6'd4 : 6'd5;
      default: t.op = 6'd2;
    endcase
    t.dest  = 5'($urandom_range(0, 31));
    t.sig_b = 1'($urandom_range(0, 1));
    t.rtv   = $urandom;
    if (t.op == 6'd35 || t.op == 6'd43) begin
      t.res = 32'h200 + 32'(4 * $urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) t.res = t.res + 32'($urandom_range(1, 3));
    end else begin
      t.res = $urandom;
    end
    k = int'($urandom_range(0, 9));
    if (k < 7)      t.delay = int'($urandom_range(1, 4));
    else if (k < 9) t.delay = int'($urandom_range(TIMEOUT - 2, TIMEOUT));
    else            t.delay = int'(TIMEOUT + $urandom_range(1, 3));
    return t;
  endfunction

  // Expected beat and memory request for one accepted instruction, in program order.
  task automatic model_accept(input ins_t t);
    beat_t       b;
    req_t        r;
    bit          is_mem, mis, tout;
    logic [31:0] cur;
    is_mem     = (t.op == 6'd35) || (t.op == 6'd43);
    mis        = is_mem && (t.res % 4 != 0);
    tout       = is_mem && !mis && (t.delay > int'(TIMEOUT));
    b.dest     = t.dest;
    b.mis      = mis;
    b.berr     = tout;
    b.br       = t.sig_b && (t.op == 6'd4 || t.op == 6'd5);
    b.en       = (t.op inside {6'd0, 6'd35, [6'd8:6'd15]}) && (t.dest != 5'd0) && !mis && !tout;
    b.chk_data = !is_mem;
    b.data     = t.res;
    if (is_mem && !mis) begin
      cur     = mem_model.exists(t.res) ? mem_model[t.res] : (t.res ^ 32'hC0DE_0000);
      r.addr  = t.res;
      r.we    = (t.op == 6'd43);
      r.wdata = t.rtv;
      r.rdata = cur;
      r.delay = t.delay;
      req_q.push_back(r);
      if (t.op == 6'd35 && !tout) begin
        b.chk_data = 1'b1;
        b.data     = cur;
      end
      if (t.op == 6'd43 && !tout) mem_model[t.res] = t.rtv;
    end
    exp_q.push_back(b);
  endtask

  task automatic responder();
    req_t r;
    int   cnt;
    bit   busy;
    busy = 1'b0;
    cnt  = 0;
    r.delay = 1;
    r.rdata = '0;
    while (rand_on) begin
      @(negedge i_clk);
      i_mem_ack = 1'b0;
      if (o_mem_req) begin
        if (!busy) begin
          if (req_q.size() == 0) begin
            chk("rand_unexpected_req", 32'd1, 32'd0);
            r.delay = 1;
            r.rdata = '0;
          end else begin
            r = req_q.pop_front();
            chk("rand_mem_addr", o_mem_addr, r.addr);
            chk("rand_mem_we", {31'd0, o_mem_we}, {31'd0, r.we});
            if (r.we) chk("rand_mem_wdata", o_mem_wdata, r.wdata);
          end
          busy = 1'b1;
          cnt  = 0;
        end
        cnt++;
        if (cnt == r.delay) begin
          i_mem_ack   = 1'b1;
          i_mem_rdata = r.rdata;
          busy        = 1'b0;
        end else if (cnt >= int'(TIMEOUT)) begin
          busy = 1'b0;
        end
      end else begin
        if (busy) begin
          chk("rand_req_dropped_early", 32'd0, 32'd1);
          busy = 1'b0;
        end
        // Stray acks outside a request must be ignored.
        if ($urandom_range(0, 9) == 0) begin
          i_mem_ack   = 1'b1;
          i_mem_rdata = $urandom;
        end
      end
    end
    i_mem_ack = 1'b0;
  endtask

  task automatic monitor();
    beat_t b;
    while (rand_on) begin
      @(negedge i_clk);
      if (o_wb_valid && i_wb_ready) begin
        if (exp_q.size() == 0) begin
          chk("rand_unexpected_beat", 32'd1, 32'd0);
        end else begin
          b = exp_q.pop_front();
          n_beats++;
          chk("rand_wb_en", {31'd0, o_wb_en}, {31'd0, b.en});
          chk("rand_wb_dest", {27'd0, o_wb_dest}, {27'd0, b.dest});
          chk("rand_branch", {31'd0, o_branch_taken}, {31'd0, b.br});
          chk("rand_misalign", {31'd0, o_misalign}, {31'd0, b.mis});
          chk("rand_bus_err", {31'd0, o_bus_err}, {31'd0, b.berr});
          if (b.chk_data) chk("rand_wb_data", o_wb_data, b.data);
        end
      end
    end
  endtask

  // One lw/sw from idle. ack_at = REQ cycle carrying the ack (0 = never).
  // Returns the number of REQ cycles and the cycle (after accept) of WB_VALID.
  task automatic mem_txn(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] rtv,
                         input logic [4:0] dest, input int ack_at, input logic [31:0] rdata,
                         output int nreq, output int lat);
    i_opcode   = op;
    i_result   = addr;
    i_rt_val   = rtv;
    i_dest     = dest;
    i_sig_b    = 1'b0;
    i_in_valid = 1'b1;
    step();
    i_in_valid = 1'b0;
    nreq = 0;
    lat  = 0;
    for (int c = 1; c <= 40 && lat == 0; c++) begin
      if (o_wb_valid) begin
        lat = c;
      end else begin
        if (o_mem_req) begin
          nreq++;
          chk("txn_mem_addr", o_mem_addr, addr);
          chk("txn_mem_we", {31'd0, o_mem_we}, {31'd0, (op == 6'd43)});
          if (op == 6'd43) chk("txn_mem_wdata", o_mem_wdata, rtv);
          if (nreq == ack_at) begin
            i_mem_ack   = 1'b1;
            i_mem_rdata = rdata;
          end
        end
        step();
        i_mem_ack = 1'b0;
      end
    end
    if (lat == 0) chk("txn_no_wb_beat", 32'd0, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   nreq, lat, idx, cyc;
    ins_t cur;

    i_rst_n     = 1'b0;
    i_in_valid  = 1'b0;
    i_opcode    = '0;
    i_result    = '0;
    i_rt_val    = '0;
    i_dest      = '0;
    i_sig_b     = 1'b0;
    i_mem_rdata = '0;
    i_mem_ack   = 1'b0;
    i_wb_ready  = 1'b1;

    // ---- reset state ----
    #3;
    chk("rst_mem_req", {31'd0, o_mem_req}, 32'd0);
    chk("rst_wb_valid", {31'd0, o_wb_valid}, 32'd0);
    chk("rst_wb_en", {31'd0, o_wb_en}, 32'd0);
    chk("rst_wb_data", o_wb_data, 32'd0);
    chk("rst_flags", {29'd0, o_branch_taken, o_misalign, o_bus_err}, 32'd0);
    chk("rst_mem_addr", o_mem_addr, 32'd0);
    chk("rst_in_ready", {31'd0, o_in_ready}, 32'd1);
    step();
    step();
    i_rst_n = 1'b1;
    step();

    // ---- table-driven single-beat instructions ----
    //            op     result         dest  sb   en    data           chk  br   mis
    vecs[0]  = '{6'd0,  32'h0000_0007, 5'd3,  1'b0, 1'b1, 32'h0000_0007, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{6'd0,  32'h1111_2222, 5'd0,  1'b0, 1'b0, 32'h1111_2222, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{6'd8,  32'h1234_5678, 5'd31, 1'b0, 1'b1, 32'h1234_5678, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{6'd13, 32'hFFFF_0000, 5'd7,  1'b1, 1'b1, 32'hFFFF_0000, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{6'd4,  32'h0000_0040, 5'd5,  1'b1, 1'b0, 32'h0000_0040, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{6'd5,  32'h0000_0044, 5'd6,  1'b0, 1'b0, 32'h0000_0044, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{6'd5,  32'h0000_0048, 5'd6,  1'b1, 1'b0, 32'h0000_0048, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{6'd2,  32'h0000_1000, 5'd9,  1'b1, 1'b0, 32'h0000_1000, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{6'd35, 32'h0000_0102, 5'd4,  1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1};
    vecs[9]  = '{6'd43, 32'h0000_0107, 5'd4,  1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1};
    vecs[10] = '{6'd0,  32'hCAFE_F00D, 5'd12, 1'b1, 1'b1, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 11; i++) begin
      i_opcode   = vecs[i].op;
      i_result   = vecs[i].res;
      i_dest     = vecs[i].dest;
      i_sig_b    = vecs[i].sig_b;
      i_rt_val   = 32'h5A5A_5A5A;
      i_in_valid = 1'b1;
      step();
      i_in_valid = 1'b0;
      chk($sformatf("vec%0d_wb_valid", i), {31'd0, o_wb_valid}, 32'd1);
      chk($sformatf("vec%0d_mem_req", i), {31'd0, o_mem_req}, 32'd0);
      chk($sformatf("vec%0d_wb_en", i), {31'd0, o_wb_en}, {31'd0, vecs[i].en});
      chk($sformatf("vec%0d_wb_dest", i), {27'd0, o_wb_dest}, {27'd0, vecs[i].dest});
      if (vecs[i].chk_data) chk($sformatf("vec%0d_wb_data", i), o_wb_data, vecs[i].data);
      chk($sformatf("vec%0d_branch", i), {31'd0, o_branch_taken}, {31'd0, vecs[i].br});
      chk($sformatf("vec%0d_misalign", i), {31'd0, o_misalign}, {31'd0, vecs[i].mis});
      chk($sformatf("vec%0d_bus_err", i), {31'd0, o_bus_err}, 32'd0);
      step();
      chk($sformatf("vec%0d_idle_after", i), {31'd0, o_wb_valid}, 32'd0);
    end

    // ---- back-to-back: four adds, four beats in four cycles ----
    for (int k = 0; k < 4; k++) begin
      i_opcode   = 6'd0;
      i_result   = 32'd100 + 32'(k);
      i_dest     = 5'(k + 1);
      i_sig_b    = 1'b0;
      i_in_valid = 1'b1;
      chk($sformatf("b2b%0d_in_ready", k), {31'd0, o_in_ready}, 32'd1);
      step();
      chk($sformatf("b2b%0d_wb_valid", k), {31'd0, o_wb_valid}, 32'd1);
      chk($sformatf("b2b%0d_wb_dest", k), {27'd0, o_wb_dest}, 32'(k + 1));
      chk($sformatf("b2b%0d_wb_data", k), o_wb_data, 32'd100 + 32'(k));
    end
    i_in_valid = 1'b0;
    step();
    chk("b2b_idle_after", {31'd0, o_wb_valid}, 32'd0);

    // ---- lw with ack in the 3rd REQ cycle ----
    mem_txn(6'd35, 32'h100, 32'h0, 5'd4, 3, 32'hDEAD_BEEF, nreq, lat);
    chk("lw3_req_cycles", 32'(nreq), 32'd3);
    chk("lw3_latency", 32'(lat), 32'd4);
    chk("lw3_wb_data", o_wb_data, 32'hDEAD_BEEF);
    chk("lw3_wb_en", {31'd0, o_wb_en}, 32'd1);
    chk("lw3_mem_req_low", {31'd0, o_mem_req}, 32'd0);
    step();

    // ---- sw, ack in first REQ cycle ----
    mem_txn(6'd43, 32'h104, 32'h55, 5'd8, 1, 32'h0, nreq, lat);
    chk("sw_req_cycles", 32'(nreq), 32'd1);
    chk("sw_latency", 32'(lat), 32'd2);
    chk("sw_wb_en", {31'd0, o_wb_en}, 32'd0);
    chk("sw_flags", {30'd0, o_misalign, o_bus_err}, 32'd0);
    step();

    // ---- misaligned lw: no request at all ----
    mem_txn(6'd35, 32'h102, 32'h0, 5'd4, 1, 32'h0, nreq, lat);
    chk("mis_req_cycles", 32'(nreq), 32'd0);
    chk("mis_latency", 32'(lat), 32'd1);
    chk("mis_flag", {31'd0, o_misalign}, 32'd1);
    chk("mis_wb_en", {31'd0, o_wb_en}, 32'd0);
    step();

    // ---- lw with no ack: timeout ----
    mem_txn(6'd35, 32'h300, 32'h0, 5'd10, 0, 32'h0, nreq, lat);
    chk("tout_req_cycles", 32'(nreq), 32'(TIMEOUT));
    chk("tout_latency", 32'(lat), 32'(TIMEOUT + 1));
    chk("tout_bus_err", {31'd0, o_bus_err}, 32'd1);
    chk("tout_wb_en", {31'd0, o_wb_en}, 32'd0);
    chk("tout_mem_req_low", {31'd0, o_mem_req}, 32'd0);
    step();

    // ---- lw with ack on the final allowed cycle ----
    mem_txn(6'd35, 32'h304, 32'h0, 5'd11, int'(TIMEOUT), 32'h1357_9BDF, nreq, lat);
    chk("late_req_cycles", 32'(nreq), 32'(TIMEOUT));
    chk("late_latency", 32'(lat), 32'(TIMEOUT + 1));
    chk("late_bus_err", {31'd0, o_bus_err}, 32'd0);
    chk("late_wb_en", {31'd0, o_wb_en}, 32'd1);
    chk("late_wb_data", o_wb_data, 32'h1357_9BDF);
    step();

    // ---- beq taken, write-back stalled 5 cycles, then back-to-back accept ----
    i_wb_ready = 1'b0;
    i_opcode   = 6'd4;
    i_result   = 32'h40;
    i_dest     = 5'd7;
    i_sig_b    = 1'b1;
    i_in_valid = 1'b1;
    step();
    i_opcode = 6'd0;
    i_result = 32'h99;
    i_dest   = 5'd9;
    i_sig_b  = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("stall%0d_wb_valid", c), {31'd0, o_wb_valid}, 32'd1);
      chk($sformatf("stall%0d_branch", c), {31'd0, o_branch_taken}, 32'd1);
      chk($sformatf("stall%0d_wb_en", c), {31'd0, o_wb_en}, 32'd0);
      chk($sformatf("stall%0d_wb_dest", c), {27'd0, o_wb_dest}, 32'd7);
      chk($sformatf("stall%0d_wb_data", c), o_wb_data, 32'h40);
      chk($sformatf("stall%0d_in_ready", c), {31'd0, o_in_ready}, 32'd0);
      step();
    end
    i_wb_ready = 1'b1;
    step();
    i_in_valid = 1'b0;
    chk("stall_next_wb_valid", {31'd0, o_wb_valid}, 32'd1);
    chk("stall_next_wb_dest", {27'd0, o_wb_dest}, 32'd9);
    chk("stall_next_branch", {31'd0, o_branch_taken}, 32'd0);
    chk("stall_next_wb_en", {31'd0, o_wb_en}, 32'd1);
    step();

    // ---- asynchronous reset during REQ, then a late ack ----
    i_opcode   = 6'd35;
    i_result   = 32'h200;
    i_dest     = 5'd2;
    i_in_valid = 1'b1;
    step();
    i_in_valid = 1'b0;
    step();
    chk("arst_req_before", {31'd0, o_mem_req}, 32'd1);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("arst_mem_req", {31'd0, o_mem_req}, 32'd0);
    chk("arst_wb_valid", {31'd0, o_wb_valid}, 32'd0);
    step();
    step();
    i_rst_n   = 1'b1;
    i_mem_ack = 1'b1;
    step();
    i_mem_ack = 1'b0;
    chk("arst_late_ack_req", {31'd0, o_mem_req}, 32'd0);
    chk("arst_late_ack_wb", {31'd0, o_wb_valid}, 32'd0);
    chk("arst_in_ready", {31'd0, o_in_ready}, 32'd1);
    step();
    chk("arst_still_idle", {31'd0, o_wb_valid | o_mem_req}, 32'd0);

    // ---- randomized traffic against the transaction model ----
    rand_on = 1'b1;
    fork
      responder();
      monitor();
    join_none
    idx = 0;
    cyc = 0;
    cur = rand_ins();
    while (idx < NRAND && cyc < 20000) begin
      @(posedge i_clk);
      #1;
      cyc++;
      i_wb_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) == 0) begin
        i_in_valid = 1'b0;
      end else begin
        i_in_valid = 1'b1;
        i_opcode   = cur.op;
        i_result   = cur.res;
        i_rt_val   = cur.rtv;
        i_dest     = cur.dest;
        i_sig_b    = cur.sig_b;
      end
      @(negedge i_clk);
      if (i_in_valid && o_in_ready) begin
        model_accept(cur);
        idx++;
        cur = rand_ins();
      end
    end
    @(posedge i_clk);
    #1;
    i_in_valid = 1'b0;
    i_wb_ready = 1'b1;
    for (int c = 0; c < 300 && exp_q.size() != 0; c++) step();
    chk("rand_issued", 32'(idx), 32'(NRAND));
    chk("rand_beats", 32'(n_beats), 32'(NRAND));
    chk("rand_beats_pending", 32'(exp_q.size()), 32'd0);
    chk("rand_reqs_pending", 32'(req_q.size()), 32'd0);
    rand_on = 1'b0;
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
